vga_pattern_sequencer: RTL and testbench

Frame-synchronous controller that schedules which test pattern the VGA pattern datapath renders, and its horizontal scroll offset. It sits between the hvsync generator (vsync input) and the pattern mux. It selects the pattern automatically on a dwell timer or manually from the user input pins, and inserts blanked frames between pattern changes. All state is clocked on the pixel clock; nothing is clocked from vsync.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_frame_edge.sv | 34 +++
 rtl/vga_pattern_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-synchronous control blocks.
//
// Contents:
//   - Output widths: PATTERN_W (pattern index) and SCROLL_W (scroll offset).
//   - Internal counter widths: DWELL_W (dwell timer) and BLANK_W (blanking counter).
//   - Bit positions of the fields packed into the raw cfg_in user pins.
//   - Sequencer state encoding (seq_state_e).
//   - Mapping from scroll step code to per-frame scroll increment.
package vga_pkg;

  localparam int unsigned PATTERN_W = 3;
  localparam int unsigned SCROLL_W  = 10;
  localparam int unsigned DWELL_W   = 10;
  localparam int unsigned BLANK_W   = 4;

  // cfg_in field positions
  localparam int unsigned CFG_AUTO     = 7;
  localparam int unsigned CFG_PAT_MSB  = 6;
  localparam int unsigned CFG_PAT_LSB  = 4;
  localparam int unsigned CFG_STEP_MSB = 3;
  localparam int unsigned CFG_STEP_LSB = 2;
  localparam int unsigned CFG_FREEZE   = 1;

  // Scroll increment per frame for each step code
  localparam logic [SCROLL_W-1:0] STEP_INC_0 = SCROLL_W'(0);
  localparam logic [SCROLL_W-1:0] STEP_INC_1 = SCROLL_W'(1);
  localparam logic [SCROLL_W-1:0] STEP_INC_2 = SCROLL_W'(2);
  localparam logic [SCROLL_W-1:0] STEP_INC_3 = SCROLL_W'(4);

  typedef enum logic [0:0] {
    StShow  = 1'b0,
    StBlank = 1'b1
  } seq_state_e;

  function automatic logic [SCROLL_W-1:0] step_inc(input logic [1:0] code);
    logic [SCROLL_W-1:0] inc;
    case (code)
      2'd0:    inc = STEP_INC_0;
      2'd1:    inc = STEP_INC_1;
      2'd2:    inc = STEP_INC_2;
      default: inc = STEP_INC_3;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Frame edge detector: registers vsync and produces a registered one-clock
// frame_tick pulse the cycle after vsync becomes active. Reusable by any
// block that needs to act once per frame on the pixel clock.
//
// Ports:
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   vsync      in   vertical sync, synchronous to clk
//   frame_tick out  one-cycle pulse per frame
module vga_frame_edge #(
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic vsync_q;
  logic frame_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      frame_tick_q <= (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);
    end
  end

  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test pattern sequencer. Chooses the pattern index and
// horizontal scroll offset used by the VGA pattern datapath, either on a
// dwell timer (auto mode) or from the manual pattern pins, and inserts
// BLANK_FRAMES blanked frames on every pattern change. All state advances
// only on the clock edge that ends a frame_tick cycle.
//
// Optional feature: define PATSEQ_FREEZE_EN to let cfg_in[1] freeze the
// sequencer (scroll, counters and state hold; frame_tick keeps pulsing).
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   vsync        in   vertical sync, synchronous to clk
//   cfg_in[7:0]  in   raw user pins: [7] auto_en, [6:4] manual pattern,
//                     [3:2] scroll step code, [1] freeze (macro only)
//   pattern_sel  out  current pattern index
//   scroll       out  horizontal scroll offset
//   blank_req    out  datapath forces RGB to 0 while high
//   frame_tick   out  one-cycle pulse per frame
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 6,
  parameter int unsigned DWELL_FRAMES = 60,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync,
  input  logic [7:0]           cfg_in,
  output logic [PATTERN_W-1:0] pattern_sel,
  output logic [SCROLL_W-1:0]  scroll,
  output logic                 blank_req,
  output logic                 frame_tick
);

  localparam logic [PATTERN_W-1:0] PAT_LAST   = PATTERN_W'(NUM_PATTERNS - 1);
  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
  // Unused when BLANK_FRAMES is 0; the wrapped value is never compared then.
  localparam logic [BLANK_W-1:0]   BLANK_LAST = BLANK_W'(BLANK_FRAMES - 1);

  // cfg_in synchronizer
  logic [7:0] cfg_meta_q;
  logic [7:0] cfg_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_meta_q <= '0;
      cfg_s_q    <= '0;
    end else begin
      cfg_meta_q <= cfg_in;
      cfg_s_q    <= cfg_meta_q;
    end
  end

  logic tick;

  vga_frame_edge #(
    .VSYNC_ACTIVE (VSYNC_ACTIVE)
  ) u_frame_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .frame_tick (tick)
  );

  // Decoded configuration
  logic                 auto_en;
  logic [PATTERN_W-1:0] cfg_pat;
  logic [PATTERN_W-1:0] target;
  logic [SCROLL_W-1:0]  inc;
  logic                 freeze;
  logic                 unused_cfg;

  assign auto_en = cfg_s_q[CFG_AUTO];
  assign cfg_pat = cfg_s_q[CFG_PAT_MSB:CFG_PAT_LSB];
  assign target  = (cfg_pat > PAT_LAST) ? PAT_LAST : cfg_pat;
  assign inc     = step_inc(cfg_s_q[CFG_STEP_MSB:CFG_STEP_LSB]);

`ifdef PATSEQ_FREEZE_EN
  assign freeze     = cfg_s_q[CFG_FREEZE];
  assign unused_cfg = cfg_s_q[0];
`else
  assign freeze     = 1'b0;
  assign unused_cfg = ^cfg_s_q[1:0];
`endif

  // Sequencer state
  seq_state_e           state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] pending_q, pending_d;
  logic [SCROLL_W-1:0]  scroll_q, scroll_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;

  logic [PATTERN_W-1:0] pat_next;
  logic [PATTERN_W-1:0] want;
  logic                 change;

  assign pat_next = (pat_q == PAT_LAST) ? '0 : pat_q + PATTERN_W'(1);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    pending_d = pending_q;
    scroll_d  = scroll_q;
    dwell_d   = dwell_q;
    blank_d   = blank_q;
    want      = pending_q;
    change    = 1'b0;

    if (tick && !freeze) begin
      unique case (state_q)
        StShow: begin
          scroll_d = scroll_q + inc;
          if (auto_en) begin
            if (dwell_q == DWELL_LAST) begin
              dwell_d = '0;
              want    = pat_next;
              change  = 1'b1;
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end else begin
            // Leaving auto mode clears the dwell timer on the same tick
            // that the manual compare is evaluated.
            dwell_d = '0;
            if (target != pat_q) begin
              want   = target;
              change = 1'b1;
            end
          end

          if (change) begin
            scroll_d = '0;
            if (BLANK_FRAMES == 0) begin
              pat_d = want;
            end else begin
              state_d   = StBlank;
              blank_d   = '0;
              pending_d = want;
            end
          end
        end

        StBlank: begin
          // pending is latched on entry; cfg is not looked at here.
          scroll_d = '0;
          if (blank_q == BLANK_LAST) begin
            pat_d   = pending_q;
            state_d = StShow;
            blank_d = '0;
          end else begin
            blank_d = blank_q + BLANK_W'(1);
          end
        end

        default: state_d = StShow;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StShow;
      pat_q     <= '0;
      pending_q <= '0;
      scroll_q  <= '0;
      dwell_q   <= '0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      pending_q <= pending_d;
      scroll_q  <= scroll_d;
      dwell_q   <= dwell_d;
      blank_q   <= blank_d;
    end
  end

  assign pattern_sel = pat_q;
  assign scroll      = scroll_q;
  assign blank_req   = (state_q == StBlank);
  assign frame_tick  = tick;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer. Two instances share inputs:
// dut_a blanks for 2 frames on a change, dut_b has no blanking. Each frame
// the stimulus advances a frame-level reference model and queues the
// expected outputs; a monitor pops and compares after every frame_tick.
module tb_vga_pattern_sequencer;

  localparam int NP    = 6;
  localparam int DWELL = 4;
  localparam int NB_A  = 2;
  localparam int NB_B  = 0;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic [7:0] cfg_in;

  logic [2:0] pat_a, pat_b;
  logic [9:0] scroll_a, scroll_b;
  logic       blank_a, blank_b;
  logic       tick_a, tick_b;

  vga_pattern_sequencer #(
    .NUM_PATTERNS (NP),
    .DWELL_FRAMES (DWELL),
    .BLANK_FRAMES (NB_A),
    .VSYNC_ACTIVE (1'b0)
  ) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .cfg_in      (cfg_in),
    .pattern_sel (pat_a),
    .scroll      (scroll_a),
    .blank_req   (blank_a),
    .frame_tick  (tick_a)
  );

  vga_pattern_sequencer #(
    .NUM_PATTERNS (NP),
    .DWELL_FRAMES (DWELL),
    .BLANK_FRAMES (NB_B),
    .VSYNC_ACTIVE (1'b0)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .cfg_in      (cfg_in),
    .pattern_sel (pat_b),
    .scroll      (scroll_b),
    .blank_req   (blank_b),
    .frame_tick  (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pat;
    int scroll;
    int shown;       // frames shown of the current pattern in auto mode
    int blank_left;  // blanked frames still to go
    int pending;
  } model_t;

  typedef struct {
    int pat;
    int scroll;
    int blank;
  } exp_t;

  model_t ma, mb;
  exp_t   qa[$];
  exp_t   qb[$];
  int     tests = 0;
  int     fails = 0;
  int     frames = 0;
  int     ticks_a = 0;
  int     ticks_b = 0;
  bit     prev_tick = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame of the sequencer as described behaviourally.
  function automatic model_t model_tick(input model_t m_in, input logic [7:0] cfg,
                                        input int nblank);
    model_t m;
    int     inc;
    int     want;
    bit     change;
    bit     frz;
    m      = m_in;
    frz    = 1'b0;
    change = 1'b0;
    want   = 0;
`ifdef PATSEQ_FREEZE_EN
    frz = cfg[1];
`endif
    if (frz) return m;
    if (m.blank_left > 0) begin
      m.blank_left--;
      if (m.blank_left == 0) m.pat = m.pending;
      return m;
    end
    case (cfg[3:2])
      2'd0:    inc = 0;
      2'd1:    inc = 1;
      2'd2:    inc = 2;
      default: inc = 4;
    endcase
    m.scroll = (m.scroll + inc) % 1024;
    if (cfg[7]) begin
      m.shown++;
      if (m.shown == DWELL) begin
        m.shown = 0;
        want    = (m.pat + 1) % NP;
        change  = 1'b1;
      end
    end else begin
      m.shown = 0;
      want    = int'(cfg[6:4]);
      if (want > NP - 1) want = NP - 1;
      if (want != m.pat) change = 1'b1;
    end
    if (change) begin
      m.scroll = 0;
      if (nblank == 0) begin
        m.pat = want;
      end else begin
        m.blank_left = nblank;
        m.pending    = want;
      end
    end
    return m;
  endfunction

  function automatic exp_t to_exp(input model_t m);
    exp_t e;
    e.pat    = m.pat;
    e.scroll = m.scroll;
    e.blank  = (m.blank_left > 0) ? 1 : 0;
    return e;
  endfunction

  // Monitor: outputs are compared on the cycle after each frame_tick.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_tick = 1'b0;
    end else begin
      if (prev_tick) begin
        if (qa.size() == 0) begin
          check("unexpected_tick_a", 1, 0);
        end else begin
          e = qa.pop_front();
          check("pattern_a", int'(pat_a), e.pat);
          check("scroll_a", int'(scroll_a), e.scroll);
          check("blank_a", int'(blank_a), e.blank);
        end
        if (qb.size() == 0) begin
          check("unexpected_tick_b", 1, 0);
        end else begin
          e = qb.pop_front();
          check("pattern_b", int'(pat_b), e.pat);
          check("scroll_b", int'(scroll_b), e.scroll);
          check("blank_b", int'(blank_b), e.blank);
        end
      end
      prev_tick = tick_a;
      if (tick_a) ticks_a++;
      if (tick_b) ticks_b++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_pat_a"}, int'(pat_a), 0);
    check({tag, "_scroll_a"}, int'(scroll_a), 0);
    check({tag, "_blank_a"}, int'(blank_a), 0);
    check({tag, "_tick_a"}, int'(tick_a), 0);
    check({tag, "_pat_b"}, int'(pat_b), 0);
    check({tag, "_scroll_b"}, int'(scroll_b), 0);
    check({tag, "_blank_b"}, int'(blank_b), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vsync = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    ma = '{default: 0};
    mb = '{default: 0};
    repeat (2) @(negedge clk);
    check_zero("after_reset");
  endtask

  // One frame: vsync inactive for 6 clocks, active for low_cycles clocks.
  task automatic do_frame(input logic [7:0] cfg, input int low_cycles = 2);
    @(negedge clk);
    cfg_in = cfg;
    vsync  = 1'b1;
    repeat (6) @(negedge clk);
    ma = model_tick(ma, cfg, NB_A);
    mb = model_tick(mb, cfg, NB_B);
    qa.push_back(to_exp(ma));
    qb.push_back(to_exp(mb));
    frames++;
    vsync = 1'b0;
    repeat (low_cycles) @(negedge clk);
  endtask

  initial begin
    logic [7:0] cfg;
    rst_n  = 1'b0;
    vsync  = 1'b1;
    cfg_in = 8'h00;
    ma     = '{default: 0};
    mb     = '{default: 0};

    // Reset, then a few frames with vsync held low longer than one cycle
    do_reset();
    for (int i = 0; i < 3; i++) do_frame(8'h00, 8);

    // Auto cycling through all patterns and the wrap to 0
    for (int i = 0; i < 40; i++) do_frame(8'h80);

    // Scroll step 4, wraps 1020 -> 0 at tick 256
    do_reset();
    for (int i = 0; i < 260; i++) do_frame(8'h0C);

    // Manual change, retarget attempted during blanking
    do_reset();
    do_frame(8'h00);
    do_frame(8'h00);
    do_frame(8'h30);
    do_frame(8'h50);
    for (int i = 0; i < 5; i++) do_frame(8'h50);

    // Clamp of out-of-range manual target
    for (int i = 0; i < 4; i++) do_frame(8'h70);

    // Reset in the middle of blanking
    do_frame(8'h20);
    do_reset();
    do_frame(8'h00);

    // Freeze / resume (freeze only acts when the feature is built in)
    do_reset();
    do_frame(8'h0C);
    do_frame(8'h0C);
    for (int i = 0; i < 5; i++) do_frame(8'h0E);
    do_frame(8'h0C);
    do_frame(8'h0C);

    // Randomized configuration, mostly held for a few frames at a time
    cfg = 8'h80;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) cfg = 8'($urandom);
      do_frame(cfg);
    end

    repeat (4) @(negedge clk);
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    check("tick_count_a", ticks_a, frames);
    check("tick_count_b", ticks_b, frames);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
